// File: rtl/mod241_residue_acc.sv
// mod241_residue_acc
//   Sums NTERMS 8-bit partial residues modulo 241 and presents the fully
//   reduced residue (0..240) on a valid/ready output port. Consecutive
//   groups never mix terms; a group's result is held until it is taken.
//
// Parameters
//   NTERMS     partial residues summed per result (1..16)
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   in_res     partial residue from the LUT stage (0..255 accepted)
//   in_valid   in_res is valid this cycle
//   in_ready   block can accept a term this cycle
//   out_res    reduced sum, 0..240 while out_valid is high
//   out_valid  out_res holds a completed result
//   out_ready  downstream accepts the result
//   err        sticky flag: a term >= 241 was seen
//
// Build option
//   MOD241_ACC_RANGE_CHECK_EN  when defined, builds the input range check
//                              driving err; otherwise err is tied to 0.

module mod241_residue_acc #(
  parameter int NTERMS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_res,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_res,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       err
);

  localparam int              CW     = $clog2(NTERMS + 1);
  localparam logic [CW-1:0]   LAST   = CW'(NTERMS - 1);
  localparam logic [CW-1:0]   ONE    = CW'(1);
  localparam bit              SINGLE = (NTERMS == 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic            in_fire;
  logic [7:0]      acc_base;
  logic [8:0]      sum;
  logic [7:0]      sum_red;

  // acc <= 240 and in_res <= 255, so the sum is at most 495 and at most
  // two subtractions of 241 bring it back into 0..240.
  function automatic logic [7:0] mod241_reduce(input logic [8:0] s);
    logic [8:0] r;
    if (s >= 9'd482)      r = s - 9'd482;
    else if (s >= 9'd241) r = s - 9'd241;
    else                  r = s;
    return r[7:0];
  endfunction

  assign in_ready  = (state_q != DONE);
  assign out_valid = (state_q == DONE);
  assign out_res   = acc_q;
  assign in_fire   = in_valid && in_ready;

  // acc_q still holds the previous result while idle, so the first term of
  // a group starts from zero instead.
  assign acc_base = (state_q == IDLE) ? 8'd0 : acc_q;
  assign sum      = {1'b0, acc_base} + {1'b0, in_res};
  assign sum_red  = mod241_reduce(sum);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_fire) begin
          acc_d   = sum_red;
          cnt_d   = ONE;
          state_d = SINGLE ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        if (in_fire) begin
          acc_d = sum_red;
          cnt_d = cnt_q + ONE;
          if (cnt_q == LAST) state_d = DONE;
        end
      end
      DONE: begin
        // A term offered now stays stalled; it is taken next cycle in IDLE.
        if (out_ready) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= 8'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef MOD241_ACC_RANGE_CHECK_EN
  logic err_q, err_d;

  assign err_d = err_q | (in_fire && (in_res >= 8'd241));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mod241_residue_acc.sv
module tb_mod241_residue_acc;

  localparam int NT = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_res;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_res;
  logic       out_valid;
  logic       out_ready;
  logic       err;

  logic [7:0] in_res1;
  logic       in_valid1;
  logic       in_ready1;
  logic [7:0] out_res1;
  logic       out_valid1;
  logic       out_ready1;
  logic       err1;

  int n_checks = 0;
  int n_errors = 0;
  int n_results = 0;

  int grp_sum = 0;
  int grp_cnt = 0;
  int exp_q[$];

`ifdef MOD241_ACC_RANGE_CHECK_EN
  localparam logic ERR_ON_BAD = 1'b1;
`else
  localparam logic ERR_ON_BAD = 1'b0;
`endif

  always #5 clk = ~clk;

  mod241_residue_acc #(.NTERMS(NT)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_res    (in_res),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_res   (out_res),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .err       (err)
  );

  mod241_residue_acc #(.NTERMS(1)) dut1 (
    .clk       (clk),
    .rst       (rst),
    .in_res    (in_res1),
    .in_valid  (in_valid1),
    .in_ready  (in_ready1),
    .out_res   (out_res1),
    .out_valid (out_valid1),
    .out_ready (out_ready1),
    .err       (err1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance to one time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a term and hold it until it transfers; the model records it.
  task automatic send(input logic [7:0] v);
    logic rdy;
    int   guard;
    guard    = 0;
    in_valid = 1'b1;
    in_res   = v;
    do begin
      rdy = in_ready;
      step();
      guard++;
    end while (!rdy && guard < 100);
    in_valid = 1'b0;
    if (!rdy) begin
      chk("accept_timeout", 32'd0, 32'd1);
    end else begin
      grp_sum += int'(v);
      grp_cnt++;
      if (grp_cnt == NT) begin
        exp_q.push_back(grp_sum % 241);
        grp_sum = 0;
        grp_cnt = 0;
      end
    end
  endtask

  // Scoreboard: every result transfer is matched against the model.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      n_results++;
      if (exp_q.size() == 0) chk("sb_unexpected", {24'd0, out_res}, 32'hFFFF);
      else                   chk("sb_result", {24'd0, out_res}, exp_q.pop_front());
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    in_res     = 8'd0;
    in_valid   = 1'b0;
    out_ready  = 1'b1;
    in_res1    = 8'd0;
    in_valid1  = 1'b0;
    out_ready1 = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
    chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_res",   {24'd0, out_res},   32'd0);
    chk("rst_err",       {31'd0, err},       32'd0);

    // 240 x4 back-to-back: result one cycle after the 4th transfer.
    for (int i = 0; i < 4; i++) send(8'd240);
    chk("t1_out_valid", {31'd0, out_valid}, 32'd1);
    chk("t1_out_res",   {24'd0, out_res},   32'd237);
    chk("t1_in_ready",  {31'd0, in_ready},  32'd0);
    step();
    chk("t1_valid_drop", {31'd0, out_valid}, 32'd0);
    chk("t1_ready_back", {31'd0, in_ready},  32'd1);

    // 255 x4: out of range terms, err sticky from after the first one.
    send(8'd255);
    chk("t2_err_first", {31'd0, err}, {31'd0, ERR_ON_BAD});
    for (int i = 0; i < 3; i++) send(8'd255);
    chk("t2_out_res", {24'd0, out_res}, 32'd56);
    step();
    chk("t2_err_sticky", {31'd0, err}, {31'd0, ERR_ON_BAD});

    // 0,0,0,5 with gaps: counter advances only on transfers.
    send(8'd0); step();
    send(8'd0); step();
    send(8'd0); step();
    chk("t3_no_early_valid", {31'd0, out_valid}, 32'd0);
    send(8'd5);
    chk("t3_out_valid", {31'd0, out_valid}, 32'd1);
    chk("t3_out_res",   {24'd0, out_res},   32'd5);
    step();

    // Backpressure: result 100 held for 10 cycles while a term is stalled.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(8'd25);
    in_valid = 1'b1;
    in_res   = 8'd7;
    for (int i = 0; i < 10; i++) begin
      chk("t4_hold_valid", {31'd0, out_valid}, 32'd1);
      chk("t4_hold_res",   {24'd0, out_res},   32'd100);
      chk("t4_hold_ready", {31'd0, in_ready},  32'd0);
      step();
    end
    out_ready = 1'b1;
    step();
    chk("t4_idle_ready", {31'd0, in_ready},  32'd1);
    chk("t4_idle_valid", {31'd0, out_valid}, 32'd0);
    send(8'd7);
    send(8'd8);
    send(8'd9);
    send(8'd10);
    chk("t4_next_res", {24'd0, out_res}, 32'd34);
    step();

    // Reset mid-group discards partial state.
    send(8'd200);
    send(8'd200);
    rst = 1'b1;
    #1;
    chk("t5_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("t5_rst_res",   {24'd0, out_res},   32'd0);
    chk("t5_rst_ready", {31'd0, in_ready},  32'd1);
    chk("t5_rst_err",   {31'd0, err},       32'd0);
    grp_sum = 0;
    grp_cnt = 0;
    step();
    rst = 1'b0;
    step();
    for (int i = 1; i <= 4; i++) send(8'(i));
    chk("t5_out_res", {24'd0, out_res}, 32'd10);
    step();

    // NTERMS=1 instance: single term 241 reduces to 0.
    in_valid1 = 1'b1;
    in_res1   = 8'd241;
    step();
    in_valid1 = 1'b0;
    chk("t6_out_valid", {31'd0, out_valid1}, 32'd1);
    chk("t6_out_res",   {24'd0, out_res1},   32'd0);
    chk("t6_in_ready",  {31'd0, in_ready1},  32'd0);
    chk("t6_err",       {31'd0, err1},       {31'd0, ERR_ON_BAD});
    step();
    chk("t6_valid_drop", {31'd0, out_valid1}, 32'd0);

    step();
    step();
    chk("sb_drained",    exp_q.size(), 32'd0);
    chk("sb_result_cnt", n_results,    32'd6);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
